wb_writeback_arbiter: RTL

- Writer side of the integer register file.
- Merges single-cycle ALU results and variable-latency load responses into the file's single write port (we / dest reg / write data).
- Load responses are buffered in a small FIFO and sign/zero-extended per funct3 before writeback.
- Output is registered, so the file sees exactly one write per cycle at most.

---
 rtl/wb_writeback_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wb_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win the port, load responses are formatted and queued.
// Optional WB_SQUASH_EN: queued loads overtaken by a younger ALU write to the same rd are dropped.
module wb_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid_i,
    input  logic [4:0]       alu_rd_i,
    input  logic [31:0]      alu_data_i,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    input  logic [4:0]       ld_rd_i,
    input  logic [31:0]      ld_rdata_i,
    input  logic [2:0]       ld_funct3_i,
    input  logic [1:0]       ld_addr_lo_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_rd_o,
    output logic [31:0]      rf_wdata_o,
    output logic [CNT_W-1:0] fifo_count_o,
    output logic             err_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       rd_mem_q [DEPTH];
    logic [4:0]       rd_mem_d [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      data_mem_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      wdata_q, wdata_d;

    logic        empty, full, ld_accept, ld_keep, alu_sel;
    logic        ld_illegal, push, push_live, head_live;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_fmt;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign ld_ready_o = !full;
    assign ld_accept  = ld_valid_i && ld_ready_o;
    // An accepted load to x0 is consumed but never reaches the file.
    assign ld_keep    = ld_accept && (ld_rd_i != 5'd0);
    assign alu_sel    = alu_valid_i && (alu_rd_i != 5'd0);

    always_comb begin
        byte_sel   = ld_rdata_i[7:0];
        half_sel   = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        ld_fmt     = ld_rdata_i;
        ld_illegal = 1'b0;
        case (ld_addr_lo_i)
            2'd0:    byte_sel = ld_rdata_i[7:0];
            2'd1:    byte_sel = ld_rdata_i[15:8];
            2'd2:    byte_sel = ld_rdata_i[23:16];
            default: byte_sel = ld_rdata_i[31:24];
        endcase
        case (ld_funct3_i)
            3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
            3'b010:  ld_fmt = ld_rdata_i;
            3'b100:  ld_fmt = {24'd0, byte_sel};
            3'b101:  ld_fmt = {16'd0, half_sel};
            default: begin
                ld_fmt     = ld_rdata_i;
                ld_illegal = 1'b1;
            end
        endcase
    end

`ifdef WB_SQUASH_EN
    assign head_live = live_q[rd_ptr_q];
`else
    assign head_live = 1'b1;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        live_d     = live_q;
        err_d      = err_q | (ld_accept && ld_illegal);
        we_d       = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        push       = 1'b0;
        push_live  = 1'b1;
        count_d    = count_q;

        if (alu_sel) begin
            we_d    = 1'b1;
            rd_d    = alu_rd_i;
            wdata_d = alu_data_i;
            push    = ld_keep;
`ifdef WB_SQUASH_EN
            // Stale loads to the same rd must never land after this younger value.
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_mem_q[i] == alu_rd_i) live_d[i] = 1'b0;
            end
            push_live = (ld_rd_i != alu_rd_i);
`endif
        end else if (!empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_d - 1'b1;
            push     = ld_keep;
            if (head_live) begin
                we_d    = 1'b1;
                rd_d    = rd_mem_q[rd_ptr_q];
                wdata_d = data_mem_q[rd_ptr_q];
            end
        end else if (ld_keep) begin
            we_d    = 1'b1;
            rd_d    = ld_rd_i;
            wdata_d = ld_fmt;
        end

        if (push) begin
            rd_mem_d[wr_ptr_q]   = ld_rd_i;
            data_mem_d[wr_ptr_q] = ld_fmt;
            live_d[wr_ptr_q]     = push_live;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            count_d              = count_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            rd_q     <= 5'd0;
            wdata_q  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            live_q     <= live_d;
            err_q      <= err_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    assign rf_we_o      = we_q;
    assign rf_rd_o      = rd_q;
    assign rf_wdata_o   = wdata_q;
    assign fifo_count_o = count_q;
    assign err_o        = err_q;

endmodule
